// File: rtl/uart_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx_if
//  Description : Handshake/serial bundle between the TX controller, the baud
//                generator tick and the UART transmitter.
//                master = controller side, slave = transmitter side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_tx_if #(
    parameter int DBIT = 8
);
    logic            tx_start;
    logic            s_tick;
    logic [DBIT-1:0] din;
    logic            tx_done_tick;
    logic            tx_busy;
    logic            tx;

    modport master (
        output tx_start,
        output s_tick,
        output din,
        input  tx_done_tick,
        input  tx_busy,
        input  tx
    );

    modport slave (
        input  tx_start,
        input  s_tick,
        input  din,
        output tx_done_tick,
        output tx_busy,
        output tx
    );
endinterface
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_tx
//  Description : UART serial transmitter. Sends start bit, DBIT data bits LSB
//                first, optional even parity bit, then a stop bit of SB_TICK
//                oversampling ticks (16 ticks per bit period).
//                Optional feature macro: UART_TX_PARITY_EN (adds parity bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_tx #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16
) (
    input  logic      clk,
    input  logic      reset,
    uart_tx_if.slave  bus
);

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_STOP   = 3'd3,
        ST_PARITY = 3'd4
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } state_t;
`endif

    // Last tick index of a normal bit, of the stop bit, and last data index.
    localparam logic [4:0] C_BIT_LAST  = 5'd15;
    localparam logic [4:0] C_STOP_LAST = 5'(SB_TICK - 1);
    localparam logic [2:0] C_N_LAST    = 3'(DBIT - 1);

    state_t          r_state;
    logic [4:0]      r_s;
    logic [2:0]      r_n;
    logic [DBIT-1:0] r_shift;
    logic            r_tx;
    logic            r_busy;
`ifdef UART_TX_PARITY_EN
    logic            r_parity;
`endif

    logic w_bit_end;
    logic w_stop_end;

    // Bit boundaries only ever happen on an oversampling tick.
    assign w_bit_end  = bus.s_tick && (r_s == C_BIT_LAST);
    assign w_stop_end = bus.s_tick && (r_s == C_STOP_LAST);

    // Done pulse is combinational so it lands on the very last stop tick.
    assign bus.tx_done_tick = (r_state == ST_STOP) && w_stop_end;
    assign bus.tx_busy      = r_busy;
    assign bus.tx           = r_tx;

    // Frame sequencer: state, counters, shift register and line level
    // all update on the same edge so tx and tx_busy track the state exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= ST_IDLE;
            r_s      <= 5'd0;
            r_n      <= 3'd0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_tx <= 1'b1;
                    // A tick coincident with acceptance is deliberately not
                    // counted: the start bit counter begins from zero here.
                    if (bus.tx_start) begin
                        r_state  <= ST_START;
                        r_shift  <= bus.din;
                        r_s      <= 5'd0;
                        r_n      <= 3'd0;
                        r_tx     <= 1'b0;
                        r_busy   <= 1'b1;
`ifdef UART_TX_PARITY_EN
                        r_parity <= ^bus.din;
`endif
                    end
                end

                ST_START: begin
                    if (w_bit_end) begin
                        r_state <= ST_DATA;
                        r_s     <= 5'd0;
                        r_tx    <= r_shift[0];
                    end else if (bus.s_tick) begin
                        r_s <= r_s + 5'd1;
                    end
                end

                ST_DATA: begin
                    if (w_bit_end) begin
                        r_s     <= 5'd0;
                        r_shift <= r_shift >> 1;
                        if (r_n == C_N_LAST) begin
`ifdef UART_TX_PARITY_EN
                            r_state <= ST_PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_n  <= r_n + 3'd1;
                            // Next bit to present is the one about to shift
                            // into position 0.
                            r_tx <= r_shift[1];
                        end
                    end else if (bus.s_tick) begin
                        r_s <= r_s + 5'd1;
                    end
                end

`ifdef UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_bit_end) begin
                        r_state <= ST_STOP;
                        r_s     <= 5'd0;
                        r_tx    <= 1'b1;
                    end else if (bus.s_tick) begin
                        r_s <= r_s + 5'd1;
                    end
                end
`endif

                ST_STOP: begin
                    r_tx <= 1'b1;
                    // tx_start during this final cycle is ignored; the next
                    // idle cycle picks up a held request.
                    if (w_stop_end) begin
                        r_state <= ST_IDLE;
                        r_s     <= 5'd0;
                        r_busy  <= 1'b0;
                    end else if (bus.s_tick) begin
                        r_s <= r_s + 5'd1;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_s     <= 5'd0;
                    r_n     <= 3'd0;
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_tx
//  Description : Scoreboard bench for uart_tx. Stimulus pushes expected
//                frames; an independent line monitor decodes tx by counting
//                s_ticks and compares each completed frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

    localparam int DBIT    = 8;
    localparam int SB_TICK = 16;
`ifdef UART_TX_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME_TICKS = 16 * (1 + DBIT + PAR) + SB_TICK;
    localparam int PAR_AT      = 16 * (1 + DBIT) + 8;
    localparam int STOP_AT     = 16 * (1 + DBIT + PAR) + 8;

    typedef struct packed {
        logic [7:0] d;
        logic       p;
    } exp_t;

    logic clk;
    logic reset;

    uart_tx_if #(.DBIT(DBIT)) bus ();

    uart_tx #(
        .DBIT    (DBIT),
        .SB_TICK (SB_TICK)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int   n_cmp;
    int   n_fail;
    int   done_count;
    exp_t exp_q[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
        end
    endfunction

    // Baud tick: one clk wide, every 4 clk.
    initial begin
        int ph;
        ph = 0;
        bus.s_tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            ph = (ph + 1) % 4;
            bus.s_tick = (ph == 0);
        end
    end

    // Line monitor: decodes frames by counting ticks from the falling start edge.
    initial begin
        logic       in_frame;
        logic       chk_busy;
        int         tcnt;
        logic [7:0] dat;
        logic       st_bit, par_bit, stp_bit;
        exp_t       e;
        in_frame = 1'b0;
        chk_busy = 1'b0;
        tcnt = 0;
        dat = '0;
        st_bit = 1'b1; par_bit = 1'b0; stp_bit = 1'b0;
        forever begin
            @(negedge clk);
            if (chk_busy) begin
                check("busy_after_done", {31'd0, bus.tx_busy}, 32'd0);
                chk_busy = 1'b0;
            end
            if (reset) begin
                in_frame = 1'b0;
            end else begin
                if (!in_frame && bus.tx === 1'b0) begin
                    in_frame = 1'b1;
                    tcnt = 0;
                    dat = '0;
                    st_bit = 1'b1; par_bit = 1'bx; stp_bit = 1'bx;
                end
                if (in_frame && bus.s_tick) begin
                    tcnt++;
                    if (tcnt == 8) st_bit = bus.tx;
                    for (int k = 0; k < DBIT; k++)
                        if (tcnt == 24 + 16 * k) dat[k] = bus.tx;
                    if (PAR == 1 && tcnt == PAR_AT) par_bit = bus.tx;
                    if (tcnt == STOP_AT) stp_bit = bus.tx;
                end
                if (bus.tx_done_tick === 1'b1) begin
                    done_count++;
                    if (!in_frame || exp_q.size() == 0) begin
                        check("unexpected_done", {31'd0, bus.tx_done_tick}, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("frame_data",   {24'd0, dat}, {24'd0, e.d});
                        check("start_bit",    {31'd0, st_bit}, 32'd0);
                        check("stop_bit",     {31'd0, stp_bit}, 32'd1);
                        check("frame_ticks",  tcnt, FRAME_TICKS);
                        check("busy_at_done", {31'd0, bus.tx_busy}, 32'd1);
                        if (PAR == 1) check("parity_bit", {31'd0, par_bit}, {31'd0, e.p});
                    end
                    in_frame = 1'b0;
                    chk_busy = 1'b1;
                end
            end
        end
    end

    // Waits at negedges for tx_done_tick, bounded.
    task automatic wait_done(input string name);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (bus.tx_done_tick === 1'b1) seen = 1'b1;
        end
        if (!seen) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic send(input logic [7:0] d, input logic p);
        exp_t e;
        e.d = d;
        e.p = p;
        @(posedge clk);
        #1;
        bus.tx_start = 1'b1;
        bus.din      = d;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.tx_start = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Watchdog.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected end of run");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        n_cmp = 0;
        n_fail = 0;
        done_count = 0;
        reset = 1'b1;
        bus.tx_start = 1'b1;
        bus.din = 8'hA5;

        // Reset held with a pending request: line idle, nothing starts.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("reset_tx",   {31'd0, bus.tx}, 32'd1);
            check("reset_busy", {31'd0, bus.tx_busy}, 32'd0);
            check("reset_done", {31'd0, bus.tx_done_tick}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.tx_start = 1'b0;
        reset = 1'b0;
        idle_cycles(3);
        check("post_reset_busy", {31'd0, bus.tx_busy}, 32'd0);

        // Single frame 0xA5.
        send(8'hA5, 1'b0);
        wait_done("a5");
        idle_cycles(10);

        // Busy rejection: 0xFF pulsed mid-data of a 0x3C frame.
        send(8'h3C, 1'b0);
        idle_cycles(120);
        bus.tx_start = 1'b1;
        bus.din      = 8'hFF;
        idle_cycles(1);
        bus.tx_start = 1'b0;
        bus.din      = 8'h00;
        wait_done("3c");
        idle_cycles(300);
        check("no_second_frame_busy", {31'd0, bus.tx_busy}, 32'd0);
        check("no_second_frame_tx",   {31'd0, bus.tx}, 32'd1);

        // Back-to-back: request held through two frames.
        @(posedge clk);
        #1;
        bus.tx_start = 1'b1;
        bus.din      = 8'h00;
        e.d = 8'h00; e.p = 1'b0;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        bus.din = 8'h55;
        e.d = 8'h55; e.p = 1'b0;
        exp_q.push_back(e);
        wait_done("b2b_first");
        @(negedge clk);
        check("b2b_gap_busy", {31'd0, bus.tx_busy}, 32'd0);
        check("b2b_gap_tx",   {31'd0, bus.tx}, 32'd1);
        @(negedge clk);
        check("b2b_restart_busy", {31'd0, bus.tx_busy}, 32'd1);
        check("b2b_restart_tx",   {31'd0, bus.tx}, 32'd0);
        @(posedge clk);
        #1;
        bus.tx_start = 1'b0;
        wait_done("b2b_second");
        idle_cycles(10);

        // Mid-frame reset during data bit 3 (frame not expected to complete).
        @(posedge clk);
        #1;
        bus.tx_start = 1'b1;
        bus.din      = 8'hF0;
        @(posedge clk);
        #1;
        bus.tx_start = 1'b0;
        repeat (288) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        check("async_reset_tx",   {31'd0, bus.tx}, 32'd1);
        check("async_reset_busy", {31'd0, bus.tx_busy}, 32'd0);
        check("async_reset_done", {31'd0, bus.tx_done_tick}, 32'd0);
        idle_cycles(3);
        reset = 1'b0;
        idle_cycles(3);
        send(8'h96, 1'b0);
        wait_done("after_reset");
        idle_cycles(10);

`ifdef UART_TX_PARITY_EN
        send(8'h07, 1'b1);
        wait_done("par07");
        idle_cycles(10);
        send(8'h03, 1'b0);
        wait_done("par03");
        idle_cycles(10);
        check("frames_done", done_count, 7);
`else
        check("frames_done", done_count, 5);
`endif
        check("scoreboard_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

Serial transmitter for the UART datapath. It consumes the oversampling `s_tick` pulse from the mod-M baud-rate counter, which produces 16 ticks per bit period. It converts a parallel byte into an asynchronous frame on `tx`: start bit, DBIT data bits LSB first, optional parity, then stop. It sits between the TX FIFO/controller, which drives `tx_start`/`din`, and the board UART pin.

## Interface
- `DBIT`, 8: number of data bits per frame; legal range 5..8.
- `SB_TICK`, 16: stop-bit length in s_ticks (16 = 1 stop, 24 = 1.5, 32 = 2); legal range 16..32.
- `clk`  input  1  system clock; all state updates on rising edge.
- `reset`  input  1  asynchronous, active-high reset.
- `tx_start`  input  1  one-cycle request to send `din`; honoured only in idle.
- `s_tick`  input  1  oversampling enable from baud generator, one `clk` wide, 16 per bit.
- `din`  input  DBIT  data word; sampled on the edge that accepts `tx_start`.
- `tx_done_tick`  output  1  one-cycle pulse at the end of the stop bit.
- `tx_busy`  output  1  high whenever state ≠ idle.
- `tx`  output  1  serial line; registered; idle level 1.

## Operation
- States:
  - idle: `tx`=1; `tx_start`=1 moves to start, loads `din` into the shift register, clears the tick counter `s` and the bit counter `n`.
  - start: `tx`=0.
  - data: `tx` = shift-register bit 0.
  - parity: only when the macro is defined.
  - stop: `tx`=1.
- Tick counter `s` is 5 bits and advances only on `s_tick`. A bit ends on the `s_tick` where `s`=15, or `s`=SB_TICK−1 in stop; `s` then clears.
- start → data after 16 ticks.
- data: at each bit end, shift right by 1.
  - `n` is 3 bits; `n` increments while `n`<DBIT−1.
  - When `n`=DBIT−1, go to stop (or to parity).
- stop → idle after SB_TICK ticks. `tx_done_tick`=1 combinationally in that same cycle (state still stop).
- `tx_start` in any non-idle state, including the `tx_done_tick` cycle, is ignored; `din` changes while busy have no effect.
- `tx_start` and `s_tick` coincident in idle: the request is accepted, and that tick is not counted toward the start bit.
- `tx_start` is held high continuously: a new frame starts on the first idle cycle, giving exactly one `clk` of idle between frames.
- Reset values: state idle, `tx`=1, `tx_busy`=0, `tx_done_tick`=0, `s`=0, `n`=0, shift register 0.
- Reset asserted mid-frame aborts the frame immediately (asynchronously). `tx` returns to 1; no `tx_done_tick` is produced.

## Timing
- `tx`, `tx_busy` and state are all registered on the same edge.
- The edge that accepts `tx_start` drives `tx` low in the following cycle.
- Start-bit width is 15 tick periods plus the interval from acceptance to the first `s_tick`.
- Every later bit is exactly 16 tick periods; stop is SB_TICK tick periods.
- Frame length in ticks: 16·(1+DBIT) + SB_TICK (+16 with parity).
- `tx_done_tick` coincides with the last stop `s_tick`. The next edge returns the block to idle with `tx_busy`=0.

## Configuration
- `UART_TX_PARITY_EN`
  - Defined: adds a parity state between data and stop, lasting 16 ticks. `tx` = XOR of the DBIT bits of the latched word (even parity). Frame length increases by 16 ticks.
  - Undefined: no parity state or logic; data goes directly to stop.

## Test plan
- Reset: assert `reset` with `tx_start`=1 → `tx`=1, `tx_busy`=0, `tx_done_tick`=0 throughout reset; no frame starts until reset is released.
- Single frame, DBIT=8, SB_TICK=16, `s_tick` every 4 clk, `din`=8'hA5 → `tx` = 0, then 1,0,1,0,0,1,0,1, then 1.
  - Each bit after start is 64 clk wide; stop is 64 clk.
  - Exactly one `tx_done_tick`; `tx_busy` falls the cycle after it.
- Busy rejection: pulse `tx_start` with `din`=8'hFF mid-data of an 8'h3C frame → the 8'h3C frame is unchanged; no second frame follows.
- Back-to-back: `tx_start` held high with `din`=8'h00, then 8'h55 → two frames separated by a single idle `clk`; two `tx_done_tick` pulses.
- Mid-frame reset during data bit 3 → `tx`=1 asynchronously, state idle, no `tx_done_tick`; the next request sends a complete, correct frame.
- With `UART_TX_PARITY_EN`, `din`=8'h07 → parity bit 1 (16 ticks) precedes stop. With 8'h03 → parity bit 0; total frame 176 ticks.
